bram_sample_sequencer: RTL and testbench

Owns the single PS-shared BRAM port and sequences clip playback into the I2S transmitter. It walks a clip of packed stereo words starting at a programmable base address and prefetches one word ahead, so each frame request from the I2S side is answered one cycle later. It also arbitrates that same port against a writer requester, for example the sample generator or loader. All logic runs on one clock (mclk domain, tied to clk at top level).

---
 rtl/bram_sample_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_bram_sample_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sample_sequencer.sv
// bram_sample_sequencer
//   Owns the single BRAM port shared with the PS. It plays a clip of packed
//   stereo words (left in [31:16], right in [15:0]) into the I2S transmitter.
//   The clip starts at a programmable base address. One word is always
//   prefetched, so each frame request is answered exactly one cycle later.
//   The same port is also arbitrated against a single writer requester.
//
// Ports
//   clk, rst          : clock and asynchronous active-low reset
//   start/stop        : one-cycle playback control pulses (stop has priority)
//   loop_en           : restart at base after the last word
//   base_addr/clip_len: clip location, latched on an accepted start
//   smp_req           : one pulse per stereo frame from the I2S side
//   smp_left/right    : sample output
//   smp_valid         : marks smp_left/right updated
//   busy, done        : playback active / end of a non-looping clip
//   underrun          : sticky; cleared by underrun_clr
//   wr_req/addr/data  : writer request, held high until wr_gnt
//   wr_gnt            : write issued to the BRAM in this cycle
//   BRAM_*            : BRAM port (byte addressed, 1-cycle read latency)
module bram_sample_sequencer #(
   parameter int ADDR_BITS = 11,
   parameter int LEN_BITS  = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 loop_en,
   input  logic [ADDR_BITS-1:0] base_addr,
   input  logic [LEN_BITS-1:0]  clip_len,
   input  logic                 smp_req,
   output logic [15:0]          smp_left,
   output logic [15:0]          smp_right,
   output logic                 smp_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 underrun,
   input  logic                 underrun_clr,
   input  logic                 wr_req,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [31:0]          wr_data,
   output logic                 wr_gnt,
   output logic                 BRAM_clk,
   output logic                 BRAM_rst,
   output logic                 BRAM_en,
   output logic [3:0]           BRAM_we,
   output logic [31:0]          BRAM_addr,
   output logic [31:0]          BRAM_din,
   input  logic [31:0]          BRAM_dout
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [ADDR_BITS-1:0] base_q, base_d;
   logic [LEN_BITS-1:0]  len_q, len_d;
   logic [LEN_BITS-1:0]  idx_q, idx_d;
   logic [31:0]          hold_q, hold_d;
   logic [15:0]          left_q, left_d;
   logic [15:0]          right_q, right_d;
   logic                 valid_q, valid_d;
   logic                 done_q, done_d;
   logic                 underrun_q, underrun_d;
   logic                 last_rd_q, last_rd_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [31:0]          din_q, din_d;

   logic                 rd_req;
   logic                 gnt_rd;
   logic                 gnt_wr;
   logic [ADDR_BITS-1:0] rd_word;
   logic [ADDR_BITS-1:0] word_addr;
   logic                 last_idx;
   logic                 underrun_set;

   // Arbitration. A reader that is being stopped does not bother the port.
   // The writer wins a tie only right after a reader grant, which bounds
   // its wait to two cycles. Gating with rst keeps the port quiet in reset.
   assign rd_req = (state_q == S_FETCH) && !stop;
   assign gnt_wr = rst && wr_req && (!rd_req || last_rd_q);
   assign gnt_rd = rd_req && !gnt_wr;

   // Word address wraps naturally by truncation to ADDR_BITS.
   assign rd_word   = base_q + idx_q[ADDR_BITS-1:0];
   assign word_addr = gnt_wr ? wr_addr : (gnt_rd ? rd_word : addr_q);

   assign BRAM_clk  = clk;
   assign BRAM_rst  = ~rst;
   assign BRAM_en   = gnt_wr | gnt_rd;
   assign BRAM_we   = gnt_wr ? 4'hF : 4'h0;
   assign BRAM_addr = {{(32-ADDR_BITS-2){1'b0}}, word_addr, 2'b00};
   assign BRAM_din  = gnt_wr ? wr_data : din_q;
   assign wr_gnt    = gnt_wr;

   assign smp_left  = left_q;
   assign smp_right = right_q;
   assign smp_valid = valid_q;
   assign done      = done_q;
   assign underrun  = underrun_q;
   assign busy      = (state_q != S_IDLE);

   assign last_idx     = (idx_q == (len_q - LEN_BITS'(1)));
   assign underrun_set = smp_req && ((state_q == S_FETCH) || (state_q == S_WAIT));

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      len_d      = len_q;
      idx_d      = idx_q;
      hold_d     = hold_q;
      left_d     = left_q;
      right_d    = right_q;
      valid_d    = smp_req;
      done_d     = 1'b0;
      underrun_d = underrun_q;
      last_rd_d  = last_rd_q;
      addr_d     = addr_q;
      din_d      = din_q;

      case (state_q)
         S_IDLE: begin
            // Requests with nothing playing are answered with silence.
            if (smp_req) begin
               left_d  = 16'h0000;
               right_d = 16'h0000;
            end
            if (start && !stop && (clip_len != '0)) begin
               base_d  = base_addr;
               len_d   = clip_len;
               idx_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (gnt_rd) state_d = S_WAIT;
         end
         S_WAIT: begin
            hold_d  = BRAM_dout;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (smp_req) begin
               left_d  = hold_q[31:16];
               right_d = hold_q[15:0];
               if (last_idx) begin
                  idx_d = '0;
                  if (loop_en) begin
                     state_d = S_FETCH;
                  end else begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  idx_d   = idx_q + LEN_BITS'(1);
                  state_d = S_FETCH;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort: drop any in-flight read and silence the output.
      if (stop && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         hold_d  = 32'h0;
         left_d  = 16'h0000;
         right_d = 16'h0000;
         done_d  = 1'b0;
      end

      // A new underrun event takes priority over a clear in the same cycle.
      if (underrun_set)      underrun_d = 1'b1;
      else if (underrun_clr) underrun_d = 1'b0;

      if (gnt_wr)      last_rd_d = 1'b0;
      else if (gnt_rd) last_rd_d = 1'b1;

      // Address and data lines hold their last driven value when idle.
      if (gnt_wr | gnt_rd) addr_d = word_addr;
      if (gnt_wr)          din_d  = wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         hold_q     <= 32'h0;
         left_q     <= 16'h0000;
         right_q    <= 16'h0000;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
         last_rd_q  <= 1'b0;
         addr_q     <= '0;
         din_q      <= 32'h0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         hold_q     <= hold_d;
         left_q     <= left_d;
         right_q    <= right_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
         last_rd_q  <= last_rd_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
      end
   end

endmodule

// File: tb/tb_bram_sample_sequencer.sv
module tb_bram_sample_sequencer;

   localparam int ADDR_BITS = 11;
   localparam int LEN_BITS  = 12;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 start = 1'b0;
   logic                 stop = 1'b0;
   logic                 loop_en = 1'b0;
   logic [ADDR_BITS-1:0] base_addr = '0;
   logic [LEN_BITS-1:0]  clip_len = '0;
   logic                 smp_req = 1'b0;
   logic [15:0]          smp_left;
   logic [15:0]          smp_right;
   logic                 smp_valid;
   logic                 busy;
   logic                 done;
   logic                 underrun;
   logic                 underrun_clr = 1'b0;
   logic                 wr_req = 1'b0;
   logic [ADDR_BITS-1:0] wr_addr = '0;
   logic [31:0]          wr_data = 32'h0;
   logic                 wr_gnt;
   logic                 BRAM_clk;
   logic                 BRAM_rst;
   logic                 BRAM_en;
   logic [3:0]           BRAM_we;
   logic [31:0]          BRAM_addr;
   logic [31:0]          BRAM_din;
   logic [31:0]          BRAM_dout = 32'h0;

   bram_sample_sequencer #(.ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
      .base_addr(base_addr), .clip_len(clip_len), .smp_req(smp_req),
      .smp_left(smp_left), .smp_right(smp_right), .smp_valid(smp_valid),
      .busy(busy), .done(done), .underrun(underrun), .underrun_clr(underrun_clr),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .BRAM_clk(BRAM_clk), .BRAM_rst(BRAM_rst), .BRAM_en(BRAM_en),
      .BRAM_we(BRAM_we), .BRAM_addr(BRAM_addr), .BRAM_din(BRAM_din),
      .BRAM_dout(BRAM_dout)
   );

   always #5 clk = ~clk;

   // BRAM model, one-cycle read latency.
   logic [31:0] mem [2048];
   always @(posedge clk) begin
      if (BRAM_en) begin
         if (BRAM_we == 4'hF) mem[BRAM_addr[12:2]] <= BRAM_din;
         BRAM_dout <= mem[BRAM_addr[12:2]];
      end
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int done_cnt = 0;
   bit contend = 1'b0;
   bit prev_rd = 1'b0;

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      int          c;
   } exp_t;
   exp_t        sbq[$];
   logic [31:0] rdq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: scoreboard pop, read-address log, contention checks.
   always @(negedge clk) begin
      if (rst) begin
         if (done) done_cnt++;
         if (BRAM_en && BRAM_we == 4'h0) rdq.push_back(BRAM_addr);
         if (smp_valid) begin
            if (sbq.size() == 0) begin
               check("spurious_valid", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("smp_left", {16'h0, smp_left}, {16'h0, e.l});
               check("smp_right", {16'h0, smp_right}, {16'h0, e.r});
               check("smp_latency", cyc - e.c, 32'd1);
            end
         end
         if (contend) begin
            check("cont_port_busy", {31'h0, BRAM_en}, 32'd1);
            if (wr_gnt) check("cont_we", {28'h0, BRAM_we}, 32'hF);
            if (prev_rd) check("cont_alternate", {31'h0, wr_gnt}, 32'd1);
            prev_rd = BRAM_en && (BRAM_we == 4'h0);
         end else begin
            prev_rd = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bram_write(input logic [ADDR_BITS-1:0] a, input logic [31:0] d);
      int n;
      n = 0;
      wr_req  = 1'b1;
      wr_addr = a;
      wr_data = d;
      forever begin
         @(negedge clk);
         if (wr_gnt) break;
         n++;
         if (n > 8) begin
            check("wr_gnt_timeout", 32'd0, 32'd1);
            break;
         end
      end
      check("wr_we", {28'h0, BRAM_we}, 32'hF);
      @(posedge clk);
      #1 wr_req = 1'b0;
   endtask

   task automatic do_start(input logic [ADDR_BITS-1:0] b, input logic [LEN_BITS-1:0] len,
                           input logic lp, input logic with_stop);
      base_addr = b;
      clip_len  = len;
      loop_en   = lp;
      start     = 1'b1;
      stop      = with_stop;
      tick(1);
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
   endtask

   task automatic req(input logic [15:0] el, input logic [15:0] er);
      exp_t e;
      e.l = el;
      e.r = er;
      e.c = cyc;
      sbq.push_back(e);
      smp_req = 1'b1;
      tick(1);
      smp_req = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      // Reset state
      tick(3);
      check("rst_left", {16'h0, smp_left}, 32'h0);
      check("rst_right", {16'h0, smp_right}, 32'h0);
      check("rst_valid", {31'h0, smp_valid}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_underrun", {31'h0, underrun}, 32'h0);
      check("rst_bram_en", {31'h0, BRAM_en}, 32'h0);
      check("rst_bram_we", {28'h0, BRAM_we}, 32'h0);
      check("rst_bram_addr", BRAM_addr, 32'h0);
      check("rst_wr_gnt", {31'h0, wr_gnt}, 32'h0);
      rst = 1'b1;
      tick(2);

      // Basic playback of a 3-word clip
      bram_write(11'd10, 32'h0001_0002);
      bram_write(11'd11, 32'h0003_0004);
      bram_write(11'd12, 32'h0005_0006);
      bram_write(11'd2046, 32'h00A0_00A1);
      bram_write(11'd2047, 32'h00B0_00B1);
      bram_write(11'd0, 32'h00C0_00C1);
      bram_write(11'd1, 32'h00D0_00D1);
      for (int i = 0; i < 4; i++) bram_write(11'(20 + i), {16'(16'h100 + i), 16'(16'h200 + i)});
      dc = done_cnt;
      do_start(11'd10, 12'd3, 1'b0, 1'b0);
      check("busy_after_start", {31'h0, busy}, 32'd1);
      tick(7);
      req(16'd1, 16'd2);
      check("done_early1", {31'h0, done}, 32'd0);
      tick(7);
      req(16'd3, 16'd4);
      check("done_early2", {31'h0, done}, 32'd0);
      tick(7);
      req(16'd5, 16'd6);
      check("done_last", {31'h0, done}, 32'd1);
      check("busy_end", {31'h0, busy}, 32'd0);
      tick(2);

      // Wrap past the top of BRAM, looping
      rdq.delete();
      dc = done_cnt;
      do_start(11'd2046, 12'd4, 1'b1, 1'b0);
      tick(5);
      req(16'h00A0, 16'h00A1); tick(5);
      req(16'h00B0, 16'h00B1); tick(5);
      req(16'h00C0, 16'h00C1); tick(5);
      req(16'h00D0, 16'h00D1); tick(5);
      req(16'h00A0, 16'h00A1); tick(5);
      do_stop();
      check("wrap_rd_count_ge5", {31'h0, rdq.size() >= 5}, 32'd1);
      if (rdq.size() >= 5) begin
         check("wrap_a0", rdq[0], 32'h1FF8);
         check("wrap_a1", rdq[1], 32'h1FFC);
         check("wrap_a2", rdq[2], 32'h0000);
         check("wrap_a3", rdq[3], 32'h0004);
         check("wrap_a4", rdq[4], 32'h1FF8);
      end
      check("wrap_no_done", done_cnt - dc, 32'd0);
      check("wrap_busy_stop", {31'h0, busy}, 32'd0);
      tick(2);

      // Contention: writer requests continuously during playback
      wr_addr = 11'd100;
      wr_data = 32'hDEAD_BEEF;
      wr_req  = 1'b1;
      contend = 1'b1;
      do_start(11'd20, 12'd4, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick(5);
         req(16'(16'h100 + i), 16'(16'h200 + i));
      end
      tick(2);
      contend = 1'b0;
      wr_req  = 1'b0;
      check("cont_underrun", {31'h0, underrun}, 32'd0);
      tick(2);

      // Underrun
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(1);
      do_start(11'd10, 12'd3, 1'b0, 1'b0);
      req(16'd0, 16'd0);
      check("underrun_set", {31'h0, underrun}, 32'd1);
      underrun_clr = 1'b1;
      tick(1);
      underrun_clr = 1'b0;
      check("underrun_clr", {31'h0, underrun}, 32'd0);
      tick(3);
      req(16'd1, 16'd2);
      underrun_clr = 1'b1;
      req(16'd1, 16'd2);
      underrun_clr = 1'b0;
      check("underrun_set_wins", {31'h0, underrun}, 32'd1);
      underrun_clr = 1'b1;
      tick(1);
      underrun_clr = 1'b0;
      do_stop();
      tick(2);

      // Abort in WAIT
      dc = done_cnt;
      do_start(11'd10, 12'd3, 1'b0, 1'b0);
      tick(4);
      req(16'd1, 16'd2);
      tick(1);
      do_stop();
      check("abort_busy", {31'h0, busy}, 32'd0);
      check("abort_left", {16'h0, smp_left}, 32'h0);
      check("abort_right", {16'h0, smp_right}, 32'h0);
      check("abort_no_done", done_cnt - dc, 32'd0);
      tick(2);
      req(16'd0, 16'd0);
      check("idle_req_no_underrun", {31'h0, underrun}, 32'd0);
      tick(2);

      // Ignored starts
      rdq.delete();
      do_start(11'd10, 12'd0, 1'b0, 1'b0);
      tick(3);
      check("len0_busy", {31'h0, busy}, 32'd0);
      do_start(11'd10, 12'd3, 1'b0, 1'b1);
      tick(3);
      check("startstop_busy", {31'h0, busy}, 32'd0);
      check("ignored_no_reads", rdq.size(), 32'd0);

      // Async reset in HOLD
      do_start(11'd11, 12'd3, 1'b0, 1'b0);
      tick(4);
      req(16'd3, 16'd4);
      tick(4);
      check("pre_rst_left", {16'h0, smp_left}, 32'd3);
      #2 rst = 1'b0;
      #1;
      check("arst_busy", {31'h0, busy}, 32'd0);
      check("arst_left", {16'h0, smp_left}, 32'h0);
      check("arst_right", {16'h0, smp_right}, 32'h0);
      check("arst_bram_en", {31'h0, BRAM_en}, 32'h0);
      tick(2);
      rst = 1'b1;
      tick(2);
      check("sb_empty", sbq.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
